// File: rtl/sort_beat_sequencer.sv
// sort_beat_sequencer
// Meters input stream beats into a fixed-latency sorting network, buffers the
// returned sorted beats in a small result FIFO, and drains them to an output
// AXI-Stream once writeback is released. One done pulse per job.
module sort_beat_sequencer #(
    parameter int DATW       = 512,
    parameter int BEATW      = 20,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [BEATW-1:0] i_beat,
    input  logic             i_start,
    input  logic             i_writeback,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err,
    input  logic [DATW-1:0]  s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [DATW-1:0]  o_net_data,
    output logic             o_net_valid,
    input  logic [DATW-1:0]  i_net_data,
    input  logic             i_net_valid,
    output logic [DATW-1:0]  m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [BEATW-1:0]   BEAT_ONE  = BEATW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW+1:0] DEPTH_EXT = (FIFO_AW+2)'(FIFO_DEPTH);

    state_t             state;
    logic [BEATW-1:0]   beat_tot;
    logic [BEATW-1:0]   issued;
    logic [BEATW-1:0]   drained;
    logic [BEATW-1:0]   beat_last;
    logic [FIFO_AW:0]   inflight;
    logic [FIFO_AW:0]   fifo_cnt;
    logic [FIFO_AW+1:0] credit_sum;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [DATW-1:0]    fifo_mem [FIFO_DEPTH];
    logic               wb_en;
    logic               done_q;
    logic               err_q;
    logic               net_vld_p1;
    logic [DATW-1:0]    net_data_p1;

    logic               s_fire;
    logic               ret_ok;
    logic               m_fire;
    logic               job_start;
    logic               last_beat;

    // Handshake and credit decode, all from registered state (no s_tvalid -> s_tready path)
    always_comb begin
        beat_last  = beat_tot - BEAT_ONE;
        credit_sum = {1'b0, inflight} + {1'b0, fifo_cnt};
        s_tready   = (state == ST_RUN) && (issued < beat_tot) && (credit_sum < DEPTH_EXT);
        s_fire     = s_tvalid && s_tready;
        ret_ok     = i_net_valid && (inflight != '0);
        m_tvalid   = wb_en && (fifo_cnt != '0);
        m_fire     = m_tvalid && m_tready;
        last_beat  = (drained == beat_last);
        m_tlast    = m_tvalid && last_beat;
        m_tdata    = m_tvalid ? fifo_mem[rd_ptr] : '0;
        job_start  = (state == ST_IDLE) && i_start;
        o_busy     = (state != ST_IDLE);
        o_done     = done_q;
        o_err      = err_q;
        o_net_valid = net_vld_p1;
        o_net_data  = net_data_p1;
    end

    // Job FSM: latches the beat count, tracks writeback release, emits the done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            beat_tot <= '0;
            wb_en    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wb_en <= 1'b0;
                    if (i_start) begin
                        beat_tot <= i_beat;
                        if (i_beat == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A writeback pulse that arrives before any result is simply held in wb_en
                    if (i_writeback) begin
                        wb_en <= 1'b1;
                    end
                    if (m_fire && last_beat) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        wb_en  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    wb_en <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-job beat counters, cleared on an accepted start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issued  <= '0;
            drained <= '0;
        end else if (job_start) begin
            issued  <= '0;
            drained <= '0;
        end else begin
            if (s_fire) begin
                issued <= issued + BEAT_ONE;
            end
            if (m_fire) begin
                drained <= drained + BEAT_ONE;
            end
        end
    end

    // Network occupancy: issue adds a beat, a legal return removes one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight <= '0;
        end else begin
            case ({s_fire, ret_ok})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    // Result FIFO pointers and fill level; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (ret_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (m_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({ret_ok, m_fire})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Result FIFO storage; contents are only meaningful below fifo_cnt, so no reset
    always_ff @(posedge i_clk) begin
        if (ret_ok) begin
            fifo_mem[wr_ptr] <= i_net_data;
        end
    end

    // Sticky error: network returned a beat while nothing was outstanding
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (i_net_valid && (inflight == '0)) begin
            err_q <= 1'b1;
        end
    end

    // Stage p0 -> p1: register accepted input beats toward the sorting network
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            net_vld_p1  <= 1'b0;
            net_data_p1 <= '0;
        end else begin
            net_vld_p1 <= s_fire;
            if (s_fire) begin
                net_data_p1 <= s_tdata;
            end
        end
    end

endmodule

// File: tb/tb_sort_beat_sequencer.sv
// Testbench for sort_beat_sequencer: a 3-cycle network model (inverts data),
// randomized stream stimulus, and a reference model stating that the output
// stream is the network image of the accepted input stream, in order.
`timescale 1ns/1ps
module tb_sort_beat_sequencer;
    localparam int DATW       = 512;
    localparam int BEATW      = 20;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic [BEATW-1:0] i_beat;
    logic             i_start;
    logic             i_writeback;
    logic             o_done;
    logic             o_busy;
    logic             o_err;
    logic [DATW-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic [DATW-1:0]  o_net_data;
    logic             o_net_valid;
    logic [DATW-1:0]  i_net_data;
    logic             i_net_valid;
    logic [DATW-1:0]  m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;

    int n_tests = 0;
    int n_fail  = 0;

    sort_beat_sequencer #(
        .DATW(DATW), .BEATW(BEATW), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_beat(i_beat), .i_start(i_start),
        .i_writeback(i_writeback), .o_done(o_done), .o_busy(o_busy), .o_err(o_err),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .o_net_data(o_net_data), .o_net_valid(o_net_valid),
        .i_net_data(i_net_data), .i_net_valid(i_net_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Sorting-network model: fixed 3-cycle latency, output = bitwise inverse of input
    logic [2:0]      pv;
    logic [DATW-1:0] pd [3];
    logic            frc_v = 1'b0;
    logic [DATW-1:0] frc_d = '0;

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], o_net_valid};
            pd[0] <= o_net_data;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign i_net_valid = frc_v | pv[2];
    assign i_net_data  = frc_v ? frc_d : ~pd[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATW-1:0] rnd();
        logic [DATW-1:0] d;
        for (int k = 0; k < DATW/32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // Per-job observations filled by run_job
    logic [DATW-1:0] exp_q[$];
    logic [DATW-1:0] obs_q[$];
    int tlast_cnt, tlast_idx, done_cnt, done_cyc, last_hs_cyc;
    int stab_viol, acc_at_wb, sready_seen, mvalid_seen;
    bit timed_out;

    // Drives one job and records what happened; comparisons live in the test tasks
    task automatic run_job(input int n, input int wb_cyc, input int pv_pct, input int pr_pct,
                           input int budget, input int rs_cyc, input int rs_beat);
        bit              pmv, pmr, s_hs;
        logic [DATW-1:0] pmd;
        int              sent;
        exp_q.delete(); obs_q.delete();
        tlast_cnt = 0; tlast_idx = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        stab_viol = 0; acc_at_wb = -1; sready_seen = 0; mvalid_seen = 0;
        pmv = 0; pmr = 0; pmd = '0; s_hs = 0; sent = 0;
        @(negedge i_clk);
        i_beat  = BEATW'(n);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) @(negedge i_clk);
            i_writeback = (cyc == wb_cyc);
            i_start     = (cyc == rs_cyc);
            if (cyc == rs_cyc) i_beat = BEATW'(rs_beat);
            if (!s_tvalid || s_hs) begin
                if (sent < n && $urandom_range(0, 99) < pv_pct) begin
                    s_tvalid = 1'b1;
                    s_tdata  = rnd();
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = ($urandom_range(0, 99) < pr_pct);
            #1;
            if (cyc == wb_cyc) acc_at_wb = sent;
            if (s_tready) sready_seen++;
            if (m_tvalid) mvalid_seen++;
            if (pmv && !pmr && (!m_tvalid || m_tdata !== pmd)) stab_viol++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            s_hs = s_tvalid && s_tready;
            if (s_hs) begin
                exp_q.push_back(~s_tdata);
                sent++;
            end
            if (m_tvalid && m_tready) begin
                obs_q.push_back(m_tdata);
                last_hs_cyc = cyc;
                if (m_tlast) begin
                    tlast_cnt++;
                    tlast_idx = obs_q.size() - 1;
                end
            end
            pmv = m_tvalid; pmr = m_tready; pmd = m_tdata;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
        timed_out = (done_cnt == 0);
        @(posedge i_clk);
        #1;
        s_tvalid = 1'b0; m_tready = 1'b0; i_writeback = 1'b0; i_start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        n_tests++;
        if ({o_busy, o_done, o_err, s_tready, o_net_valid, m_tvalid, m_tlast} !== 7'b0 ||
            o_net_data !== '0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%b net_data_zero=%0b m_tdata_zero=%0b required all 0",
                     {o_busy, o_done, o_err, s_tready, o_net_valid, m_tvalid, m_tlast},
                     o_net_data == '0, m_tdata == '0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        // start a job and stream beats, then pull reset in the middle of a cycle
        @(negedge i_clk);
        i_beat = 20'd8; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; s_tvalid = 1'b1; s_tdata = rnd();
        repeat (3) begin
            @(negedge i_clk);
            s_tdata = rnd();
        end
        @(posedge i_clk);
        #2;
        n_tests++;
        if (o_busy !== 1'b1 || o_net_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_run: busy=%b net_valid=%b required 1 1", o_busy, o_net_valid);
        end
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_busy, o_done, o_err, s_tready, o_net_valid, m_tvalid, m_tlast} !== 7'b0 ||
            o_net_data !== '0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_async: ctrl=%b net_data_zero=%0b required all 0",
                     {o_busy, o_done, o_err, s_tready, o_net_valid, m_tvalid, m_tlast},
                     o_net_data == '0);
        end
        s_tvalid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        run_job(4, 0, 100, 100, 200, -1, 0);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (timed_out || obs_q.size() != 4 || exp_q.size() != 4 || bad >= 0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_restart: timeout=%0b out=%0d in=%0d first_bad=%0d err=%b required 0 4 4 -1 0",
                     timed_out, obs_q.size(), exp_q.size(), bad, o_err);
        end
    endtask

    task automatic test_basic();
        int bad;
        run_job(4, 0, 100, 100, 200, -1, 0);
        n_tests++;
        if (timed_out || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: timeout=%0b beats=%0d required 4", timed_out, obs_q.size());
        end
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (bad >= 0 || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_data: first_bad=%0d accepted=%0d required -1 4", bad, exp_q.size());
        end
        n_tests++;
        if (tlast_cnt != 1 || tlast_idx != 3) begin
            n_fail++;
            $display("FAIL basic_tlast: count=%0d idx=%0d required 1 3", tlast_cnt, tlast_idx);
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d at=%0d required 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1);
        end
        n_tests++;
        if (o_busy !== 1'b0 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_after: busy=%b m_tvalid=%b required 0 0", o_busy, m_tvalid);
        end
    endtask

    task automatic test_zero();
        run_job(0, 0, 100, 100, 20, -1, 0);
        n_tests++;
        if (done_cnt != 1 || done_cyc != 0) begin
            n_fail++;
            $display("FAIL zero_done: pulses=%0d at=%0d required 1 at 0", done_cnt, done_cyc);
        end
        n_tests++;
        if (sready_seen != 0 || mvalid_seen != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: s_tready_cycles=%0d m_tvalid_cycles=%0d beats=%0d required 0 0 0",
                     sready_seen, mvalid_seen, obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        run_job(40, 200, 100, 100, 2000, -1, 0);
        n_tests++;
        if (acc_at_wb != FIFO_DEPTH) begin
            n_fail++;
            $display("FAIL bp_credit: accepted_before_wb=%0d required %0d", acc_at_wb, FIFO_DEPTH);
        end
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (timed_out || obs_q.size() != 40 || exp_q.size() != 40 || bad >= 0) begin
            n_fail++;
            $display("FAIL bp_data: timeout=%0b out=%0d in=%0d first_bad=%0d required 0 40 40 -1",
                     timed_out, obs_q.size(), exp_q.size(), bad);
        end
        n_tests++;
        if (tlast_cnt != 1 || tlast_idx != 39 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_tlast_done: tlast=%0d idx=%0d done=%0d required 1 39 1",
                     tlast_cnt, tlast_idx, done_cnt);
        end
    endtask

    task automatic test_stalls();
        int bad;
        run_job(100, 5, 50, 50, 5000, -1, 0);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (timed_out || obs_q.size() != 100 || exp_q.size() != 100 || bad >= 0) begin
            n_fail++;
            $display("FAIL stall_data: timeout=%0b out=%0d in=%0d first_bad=%0d required 0 100 100 -1",
                     timed_out, obs_q.size(), exp_q.size(), bad);
        end
        n_tests++;
        if (stab_viol != 0) begin
            n_fail++;
            $display("FAIL stall_hold: unstable_cycles=%0d required 0", stab_viol);
        end
        n_tests++;
        if (tlast_cnt != 1 || tlast_idx != 99 || done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL stall_end: tlast=%0d idx=%0d done=%0d at=%0d required 1 99 1 at %0d",
                     tlast_cnt, tlast_idx, done_cnt, done_cyc, last_hs_cyc + 1);
        end
        n_tests++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_err: err=%b required 0", o_err);
        end
    endtask

    task automatic test_start_ignored();
        run_job(10, 0, 100, 70, 500, 3, 3);
        n_tests++;
        if (timed_out || obs_q.size() != 10 || tlast_idx != 9 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL restart_ignored: timeout=%0b beats=%0d tlast_idx=%0d done=%0d required 0 10 9 1",
                     timed_out, obs_q.size(), tlast_idx, done_cnt);
        end
    endtask

    task automatic test_faults();
        int bad;
        @(negedge i_clk);
        frc_v = 1'b1;
        frc_d = rnd();
        #1;
        n_tests++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_pre: err=%b required 0", o_err);
        end
        @(negedge i_clk);
        frc_v = 1'b0;
        #1;
        n_tests++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_set: err=%b required 1", o_err);
        end
        repeat (10) @(negedge i_clk);
        #1;
        n_tests++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: err=%b required 1", o_err);
        end
        // the stray beat must not have entered the result FIFO
        run_job(2, 0, 100, 100, 200, -1, 0);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (timed_out || obs_q.size() != 2 || bad >= 0 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_no_push: timeout=%0b beats=%0d first_bad=%0d err=%b required 0 2 -1 1",
                     timed_out, obs_q.size(), bad, o_err);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_beat = '0; i_start = 1'b0; i_writeback = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_stalls();
        test_start_ignored();
        test_faults();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
